lbp_window_fetch: RTL

- Upstream stage of the LBP core; owns the gray-memory read interface.
- Reads the 128x128 8-bit gray image and assembles 3x3 neighbourhoods for every interior pixel, row-major.
- Each window goes downstream with its centre address over a valid/ready handshake.
- Border pixels produce no window; the LBP result memory holds 0 there.

---
 rtl/lbp_pkg.sv | 32 +++
 rtl/lbp_window_fetch_if.sv | 29 ++
 rtl/lbp_col_shifter.sv | 43 ++++
 rtl/lbp_window_fetch.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants, FSM state type and window-index helpers for the LBP window fetch stage.
package lbp_pkg;

  localparam int LBP_IMG_W  = 128;
  localparam int LBP_IMG_H  = 128;
  localparam int LBP_ADDR_W = 14;
  localparam int LBP_DATA_W = 8;

  localparam int WIN_PIX    = 9;
  localparam int WIN_CENTRE = 4;

  // Neighbour visiting order around the centre, clockwise from top-left.
  localparam logic [3:0] NBR_ORDER [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd8, 4'd7, 4'd6, 4'd3};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    SHIFT,
    DONE
  } state_t;

  // Fetch index -> window column: LOAD walks columns left to right, SHIFT only refills the right one.
  function automatic logic [1:0] fetch_dc(input logic [3:0] idx, input logic shifting);
    return shifting ? 2'd2 : 2'(idx / 4'd3);
  endfunction

  function automatic logic [1:0] fetch_dr(input logic [3:0] idx, input logic shifting);
    return shifting ? idx[1:0] : 2'(idx % 4'd3);
  endfunction

endpackage

// File: rtl/lbp_window_fetch_if.sv
// Gray-memory read bus and downstream window handshake of the LBP fetch stage.
interface lbp_window_fetch_if
  import lbp_pkg::*;
#(
  parameter int ADDR_W = LBP_ADDR_W,
  parameter int DATA_W = LBP_DATA_W
);

  logic                  gray_ready;
  logic                  gray_req;
  logic [ADDR_W-1:0]     gray_addr;
  logic [DATA_W-1:0]     gray_data;

  logic                  win_valid;
  logic                  win_ready;
  logic [9*DATA_W-1:0]   win_data;
  logic [ADDR_W-1:0]     win_addr;

  modport master (
    input  gray_ready, gray_data, win_ready,
    output gray_req, gray_addr, win_valid, win_data, win_addr
  );

  modport slave (
    output gray_ready, gray_data, win_ready,
    input  gray_req, gray_addr, win_valid, win_data, win_addr
  );

endinterface

// File: rtl/lbp_col_shifter.sv
// 3x3 window held as three pixel columns; single-pixel load into any slot or a left shift of columns.
module lbp_col_shifter
  import lbp_pkg::*;
#(
  parameter int DATA_W = LBP_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic                load_en,
  input  logic [1:0]          load_dc,
  input  logic [1:0]          load_dr,
  input  logic [DATA_W-1:0]   load_pix,
  output logic [9*DATA_W-1:0] win_data
);

  logic [DATA_W-1:0] pix [3][3];  // [column][row]

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int dc = 0; dc < 3; dc++) begin
        for (int dr = 0; dr < 3; dr++) begin
          pix[dc][dr] <= '0;
        end
      end
    end else if (shift_en) begin
      pix[0] <= pix[1];
      pix[1] <= pix[2];
    end else if (load_en) begin
      pix[load_dc][load_dr] <= load_pix;
    end
  end

  always_comb begin
    win_data = '0;
    for (int dc = 0; dc < 3; dc++) begin
      for (int dr = 0; dr < 3; dr++) begin
        win_data[DATA_W*(3*dr+dc) +: DATA_W] = pix[dc][dr];
      end
    end
  end

endmodule

// File: rtl/lbp_window_fetch.sv
// Scans interior pixels row-major, fetching a full 3x3 at row start and one new column per step.
module lbp_window_fetch
  import lbp_pkg::*;
#(
  parameter int IMG_W  = LBP_IMG_W,
  parameter int IMG_H  = LBP_IMG_H,
  parameter int ADDR_W = LBP_ADDR_W,
  parameter int DATA_W = LBP_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  lbp_window_fetch_if.master bus,
  output logic               fetch_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = ADDR_W - COL_W;

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [3:0]         idx;

  logic               capture;
  logic               shifting;
  logic               transfer;
  logic               fetch_last;
  logic               col_more;
  logic               row_more;
  logic               shift_en;
  logic [3:0]         idx_nxt;
  logic [1:0]         cap_dc;
  logic [1:0]         cap_dr;
  logic [ROW_W-1:0]   row_nxt;
  logic [COL_W-1:0]   col_nxt;
  logic [ADDR_W-1:0]  addr_first;
  logic [ADDR_W-1:0]  addr_fetch;
  logic [ADDR_W-1:0]  addr_shift;
  logic [ADDR_W-1:0]  addr_row;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c,
                                                 input logic [1:0] dr, input logic [1:0] dc);
    return {r, c} + (ADDR_W'(dr) << COL_W) + ADDR_W'(dc) - ADDR_W'(IMG_W) - ADDR_W'(1);
  endfunction

  // A request only counts if memory was available in the cycle it was on the bus; otherwise it is reissued.
  always_comb begin
    capture    = bus.gray_req & bus.gray_ready;
    shifting   = (state == SHIFT);
    transfer   = bus.win_valid & bus.win_ready;
    idx_nxt    = idx + 4'(capture);
    fetch_last = shifting ? (idx_nxt == 4'd3) : (idx_nxt == 4'd9);
    col_more   = col < COL_W'(IMG_W - 2);
    row_more   = row < ROW_W'(IMG_H - 2);
    shift_en   = transfer & col_more;
    cap_dc     = fetch_dc(idx, shifting);
    cap_dr     = fetch_dr(idx, shifting);
    row_nxt    = row + ROW_W'(1);
    col_nxt    = col + COL_W'(1);
    addr_first = pix_addr(row, col, 2'd0, 2'd0);
    addr_fetch = pix_addr(row, col, fetch_dr(idx_nxt, shifting), fetch_dc(idx_nxt, shifting));
    addr_shift = pix_addr(row, col_nxt, 2'd0, 2'd2);
    addr_row   = pix_addr(row_nxt, COL_W'(1), 2'd0, 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      row           <= ROW_W'(1);
      col           <= COL_W'(1);
      idx           <= '0;
      bus.gray_req  <= 1'b0;
      bus.gray_addr <= '0;
      bus.win_valid <= 1'b0;
      bus.win_addr  <= '0;
      fetch_done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.gray_ready) begin
            state         <= LOAD;
            idx           <= '0;
            bus.gray_req  <= 1'b1;
            bus.gray_addr <= addr_first;
          end
        end
        LOAD, SHIFT: begin
          idx <= idx_nxt;
          if (fetch_last) begin
            state         <= EMIT;
            bus.gray_req  <= 1'b0;
            bus.win_valid <= 1'b1;
            bus.win_addr  <= {row, col};
          end else begin
            bus.gray_req  <= bus.gray_ready;
            bus.gray_addr <= addr_fetch;
          end
        end
        EMIT: begin
          if (transfer) begin
            bus.win_valid <= 1'b0;
            idx           <= '0;
            if (col_more) begin
              col           <= col_nxt;
              state         <= SHIFT;
              bus.gray_req  <= bus.gray_ready;
              bus.gray_addr <= addr_shift;
            end else if (row_more) begin
              row           <= row_nxt;
              col           <= COL_W'(1);
              state         <= LOAD;
              bus.gray_req  <= bus.gray_ready;
              bus.gray_addr <= addr_row;
            end else begin
              state      <= DONE;
              fetch_done <= 1'b1;
            end
          end
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

  lbp_col_shifter #(
    .DATA_W (DATA_W)
  ) u_cols (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .load_en  (capture),
    .load_dc  (cap_dc),
    .load_dr  (cap_dr),
    .load_pix (bus.gray_data),
    .win_data (bus.win_data)
  );

endmodule
